// File: rtl/quant_stage_pipe_if.sv
// Sample bus of one quantiser cascade stage.
// The input side is driven by the previous stage or the source; outputs go to the next stage and the final adder.
interface quant_stage_pipe_if #(
  parameter int AW = 32,
  parameter int QW = 16
);
  logic          in_valid;
  logic [AW-1:0] in_tgt;
  logic          in_sgn;
  logic          nxt_valid;
  logic [AW-1:0] nxt_tgt;
  logic          nxt_sgn;
  logic          c_valid;
  logic [QW-1:0] c;
  logic          c_sgn;

  modport master (
    output in_valid,
    output in_tgt,
    output in_sgn,
    input  nxt_valid,
    input  nxt_tgt,
    input  nxt_sgn,
    input  c_valid,
    input  c,
    input  c_sgn
  );

  modport slave (
    input  in_valid,
    input  in_tgt,
    input  in_sgn,
    output nxt_valid,
    output nxt_tgt,
    output nxt_sgn,
    output c_valid,
    output c,
    output c_sgn
  );
endinterface

// File: rtl/quant_stage_pipe.sv
// ANS-PWM cascade stage: quantises the target to QW bits and passes the residual on.
// The quantised word is delayed DEPTH enabled cycles so that it lines up at the final adder.
module quant_stage_pipe #(
  parameter int AW    = 32,
  parameter int QW    = 16,
  parameter int DEPTH = 3,
  parameter int ROUND = 0
) (
  input logic               clk,
  input logic               rst,
  input logic               en,
  input logic               clr,
  quant_stage_pipe_if.slave bus
);
  localparam int F = AW - QW;

  logic [QW-1:0] t;
  logic [F-1:0]  r;
  logic          up;
  logic [QW-1:0] q;
  logic [F-1:0]  m;
  logic          s_res;

  // Rounding up flips the residual sign; 2^F - r is the F-bit negation of r.
  always_comb begin
    t     = bus.in_tgt[AW-1:F];
    r     = bus.in_tgt[F-1:0];
    up    = (ROUND != 0) && r[F-1] && !(&t);
    q     = t;
    m     = r;
    s_res = bus.in_sgn;
    if (up) begin
      q     = t + QW'(1);
      m     = ~r + F'(1);
      s_res = ~bus.in_sgn;
    end
  end

  logic          nv;
  logic [F-1:0]  nm;
  logic          ns;
  logic          v_d [DEPTH];
  logic [QW-1:0] q_d [DEPTH];
  logic          s_d [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nv <= 1'b0;
      nm <= '0;
      ns <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        v_d[i] <= 1'b0;
        q_d[i] <= '0;
        s_d[i] <= 1'b0;
      end
    end else if (clr) begin
      nv <= 1'b0;
      nm <= '0;
      ns <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        v_d[i] <= 1'b0;
        q_d[i] <= '0;
        s_d[i] <= 1'b0;
      end
    end else if (en) begin
      nv     <= bus.in_valid;
      nm     <= m;
      ns     <= s_res;
      v_d[0] <= bus.in_valid;
      q_d[0] <= q;
      s_d[0] <= bus.in_sgn;
      for (int i = 1; i < DEPTH; i++) begin
        v_d[i] <= v_d[i-1];
        q_d[i] <= q_d[i-1];
        s_d[i] <= s_d[i-1];
      end
    end
  end

  assign bus.nxt_valid = nv;
  assign bus.nxt_tgt   = {nm, {QW{1'b0}}};
  assign bus.nxt_sgn   = ns;
  assign bus.c_valid   = v_d[DEPTH-1];
  assign bus.c         = q_d[DEPTH-1];
  assign bus.c_sgn     = s_d[DEPTH-1];
endmodule

// File: tb/tb_quant_stage_pipe.sv
// Bench for quant_stage_pipe: truncating and rounding instances fed identical stimulus.
// Expectations are queued on drive and checked, with latency, when valids appear.
module tb_quant_stage_pipe;
  localparam int AW = 32;
  localparam int QW = 16;
  localparam int DEPTH = 3;

  typedef struct packed {
    logic        nv;
    logic        ns;
    logic [31:0] nt;
    logic        cv;
    logic        cs;
    logic [15:0] c;
  } obs_t;

  typedef struct {
    int          due;
    logic [15:0] c0;
    logic [15:0] c1;
    logic        cs;
    logic [31:0] n0;
    logic [31:0] n1;
    logic        ns0;
    logic        ns1;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b1;
  logic clr = 1'b0;

  int n_chk = 0;
  int n_fail = 0;
  int ecnt = 0;
  exp_t nq[$];
  exp_t cq[$];

  quant_stage_pipe_if #(.AW(AW), .QW(QW)) b0 ();
  quant_stage_pipe_if #(.AW(AW), .QW(QW)) b1 ();

  quant_stage_pipe #(
    .AW(AW), .QW(QW), .DEPTH(DEPTH), .ROUND(0)
  ) u_trunc (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .bus(b0)
  );

  quant_stage_pipe #(
    .AW(AW), .QW(QW), .DEPTH(DEPTH), .ROUND(1)
  ) u_round (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .bus(b1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic obs_t snap0();
    return '{b0.nxt_valid, b0.nxt_sgn, b0.nxt_tgt,
             b0.c_valid, b0.c_sgn, b0.c};
  endfunction

  function automatic obs_t snap1();
    return '{b1.nxt_valid, b1.nxt_sgn, b1.nxt_tgt,
             b1.c_valid, b1.c_sgn, b1.c};
  endfunction

  task automatic model(input bit rnd,
                       input logic [31:0] tgt,
                       input logic sgn,
                       output logic [15:0] q,
                       output logic [31:0] nt,
                       output logic ns);
    int unsigned tv, rv, mv;
    tv = tgt >> 16;
    rv = tgt & 32'h0000_FFFF;
    q  = tv[15:0];
    mv = rv;
    ns = sgn;
    if (rnd && rv >= 32768 && tv != 65535) begin
      q  = 16'(tv + 1);
      mv = 65536 - rv;
      ns = ~sgn;
    end
    nt = mv << 16;
  endtask

  task automatic drive(input logic [31:0] tgt, input logic sgn);
    exp_t e;
    b0.in_tgt = tgt;
    b1.in_tgt = tgt;
    b0.in_sgn = sgn;
    b1.in_sgn = sgn;
    b0.in_valid = 1'b1;
    b1.in_valid = 1'b1;
    model(1'b0, tgt, sgn, e.c0, e.n0, e.ns0);
    model(1'b1, tgt, sgn, e.c1, e.n1, e.ns1);
    e.cs = sgn;
    e.due = ecnt + 1;
    nq.push_back(e);
    e.due = ecnt + DEPTH;
    cq.push_back(e);
  endtask

  task automatic send(input logic [31:0] tgt, input logic sgn);
    @(posedge clk);
    #1;
    drive(tgt, sgn);
  endtask

  task automatic idle(input int n);
    @(posedge clk);
    #1;
    b0.in_valid = 1'b0;
    b1.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    obs_t o0, o1;
    o0 = snap0();
    o1 = snap1();
    chk({tag, "_trunc"}, o0, 64'd0);
    chk({tag, "_round"}, o1, 64'd0);
  endtask

  // Monitor: scoreboard on enabled edges, hold check on disabled edges.
  initial begin
    obs_t o0, o1, p0, p1;
    exp_t e;
    bit f, cl;
    p0 = '0;
    p1 = '0;
    forever begin
      @(posedge clk);
      f  = en && !clr && !rst;
      cl = clr || rst;
      if (f) ecnt++;
      @(negedge clk);
      o0 = snap0();
      o1 = snap1();
      if (rst || cl) begin
      end else if (!f) begin
        chk("hold_trunc", o0, p0);
        chk("hold_round", o1, p1);
      end else begin
        if (o0.nv || o1.nv) begin
          if (nq.size() == 0) begin
            chk("nxt_spurious", 1, 0);
          end else begin
            e = nq.pop_front();
            chk("nxt_lat", ecnt, e.due);
            chk("nxt_v_trunc", o0.nv, 1);
            chk("nxt_v_round", o1.nv, 1);
            chk("nxt_tgt_trunc", o0.nt, e.n0);
            chk("nxt_tgt_round", o1.nt, e.n1);
            chk("nxt_sgn_trunc", o0.ns, e.ns0);
            chk("nxt_sgn_round", o1.ns, e.ns1);
          end
        end else if (nq.size() > 0 && nq[0].due <= ecnt) begin
          chk("nxt_missing", 0, 1);
          void'(nq.pop_front());
        end
        if (o0.cv || o1.cv) begin
          if (cq.size() == 0) begin
            chk("c_spurious", 1, 0);
          end else begin
            e = cq.pop_front();
            chk("c_lat", ecnt, e.due);
            chk("c_v_trunc", o0.cv, 1);
            chk("c_v_round", o1.cv, 1);
            chk("c_trunc", o0.c, e.c0);
            chk("c_round", o1.c, e.c1);
            chk("c_sgn_trunc", o0.cs, e.cs);
            chk("c_sgn_round", o1.cs, e.cs);
          end
        end else if (cq.size() > 0 && cq[0].due <= ecnt) begin
          chk("c_missing", 0, 1);
          void'(cq.pop_front());
        end
      end
      p0 = o0;
      p1 = o1;
    end
  end

  initial begin
    logic [31:0] v;
    b0.in_valid = 1'b0;
    b1.in_valid = 1'b0;
    b0.in_tgt = '0;
    b1.in_tgt = '0;
    b0.in_sgn = 1'b0;
    b1.in_sgn = 1'b0;
    #2;
    chk_zero("reset_state");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // Directed cases, then back-to-back boundary and random patterns.
    send(32'h1234_5678, 1'b1);
    idle(4);
    send(32'h1234_8001, 1'b1);
    send(32'hFFFF_C000, 1'b0);
    send(32'h0000_8000, 1'b1);
    send(32'h1234_7FFF, 1'b0);
    send(32'hFFFF_7FFF, 1'b1);
    send(32'hFFFE_FFFF, 1'b0);
    send(32'h0000_0000, 1'b1);
    for (int i = 0; i < 24; i++) begin
      v = $urandom;
      send(v, 1'($urandom_range(0, 1)));
    end
    idle(5);

    // Stall for two edges after the second of three samples.
    send(32'hAAAA_5555, 1'b1);
    send(32'h5555_AAAA, 1'b0);
    @(posedge clk);
    #1;
    en = 1'b0;
    drive(32'h0F0F_F0F0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    en = 1'b1;
    idle(5);

    // Asynchronous reset with two samples in flight.
    send(32'h1111_9999, 1'b1);
    send(32'h2222_1111, 1'b0);
    @(posedge clk);
    #1;
    b0.in_valid = 1'b0;
    b1.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_zero("rst_mid");
    nq.delete();
    cq.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(5);

    // Synchronous clear with en low and three samples in flight.
    send(32'h3333_C001, 1'b1);
    send(32'h4444_0001, 1'b0);
    send(32'h5555_FFFF, 1'b1);
    @(posedge clk);
    #1;
    en = 1'b0;
    clr = 1'b1;
    b0.in_valid = 1'b0;
    b1.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk_zero("clr");
    nq.delete();
    cq.delete();
    clr = 1'b0;
    en = 1'b1;
    send(32'h6666_8000, 1'b0);
    idle(6);

    chk("drain", nq.size() + cq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
